prbs_rx_checker: RTL and testbench
==================================

# prbs_rx_checker

Receive-side counterpart to the PRBS edge shaper. Takes the 16-bit shaped PRBS waveform (digital loopback or ADC capture), slices it with a hysteresis comparator, and samples one bit per symbol strobe. It self-synchronises a local reference LFSR, then counts bits and bit errors. It also measures rise and fall transition times in clock cycles, for closed-loop checking of the shaper's edge-time setting.

## Interface
- LOCK_MATCHES, 64: consecutive matching bits required in CHECK before declaring lock (range 1..255).
- LOL_WINDOW, 128: bits per loss-of-lock observation window in LOCKED.
- LOL_ERRORS, 16: errors within one window that force return to HUNT.
- dac_clk  in  1  sole clock, all logic rising edge.
- reset  in  1  asynchronous, active-high reset.
- shaped_data  in  16  unsigned waveform sample, one per dac_clk.
- sample_strobe  in  1  one-cycle pulse per symbol, positioned mid-symbol by the system.
- thr_hi  in  16  slicer upper threshold (default system value 0x5000).
- thr_lo  in  16  slicer lower threshold (0x3000); thr_lo < thr_hi is required, otherwise behaviour is undefined.
- prbs_sel  in  2  polynomial: 0=PRBS7 x^7+x^6+1, 1=PRBS15 x^15+x^14+1, 2=PRBS23 x^23+x^18+1, 3=PRBS31 x^31+x^28+1.
- clear_counters  in  1  synchronous clear of err_count and bit_count.
- rx_bit  out  1  last sampled bit.
- rx_bit_valid  out  1  one-cycle pulse, rx_bit updated.
- error_pulse  out  1  one-cycle pulse on a counted mismatch.
- lock  out  1  high while in LOCKED.
- state_dbg  out  2  HUNT=0, CHECK=1, LOCKED=2.
- err_count  out  32  saturating error count.
- bit_count  out  48  saturating compared-bit count.
- rise_time_meas  out  8  last measured rise transition, in cycles.
- fall_time_meas  out  8  last measured fall transition, in cycles.

## Operation
- **Reset values.** Every output and all internal state are 0; state is HUNT.
- **Slicer.** Registered `level` is set to 1 if shaped_data >= thr_hi. It is cleared to 0 if shaped_data <= thr_lo. Otherwise it holds.
- **Edge timer.** An 8-bit counter increments each cycle shaped_data is strictly between thr_lo and thr_hi, saturating at 255. It is cleared on any cycle the sample is outside the band.
  - On a `level` 0->1 change, the counter value (the band cycles before the crossing) is copied to rise_time_meas.
  - On a 1->0 change, it is copied to fall_time_meas.
  - An instantaneous edge reads 0.
- **Bit sampling.** On sample_strobe, `level` as it stands that cycle becomes the received bit.
- **Reference LFSR.** Fibonacci, width N = 7/15/23/31. The expected bit is the XOR of the two tap bits; the register shifts toward the MSB with the new bit entering at bit 0.
- **State HUNT.**
  - Each strobe shifts the received bit into the LFSR and increments seed_cnt.
  - When seed_cnt reaches N: if LFSR[N-1:0] is all zero, seed_cnt is reset and the state stays HUNT; else the state goes to CHECK with match_run=0.
- **State CHECK.**
  - Each strobe compares the received bit to the expected bit, then shifts the expected bit (not the received bit).
  - A match increments match_run; match_run reaching LOCK_MATCHES moves the state to LOCKED.
  - A mismatch returns to HUNT with seed_cnt=0.
  - No counters are updated in CHECK.
- **State LOCKED.**
  - Each strobe compares, shifts the expected bit, and increments bit_count (saturating at 2^48-1).
  - A mismatch increments err_count (saturating at 2^32-1), pulses error_pulse, and increments win_err.
  - A window counter spans LOL_WINDOW bits. If win_err reaches LOL_ERRORS, the state goes to HUNT immediately. At the window end, win_err is reset.
  - err_count and bit_count keep their values across loss of lock.
- **prbs_sel change.** Any change versus its registered copy forces HUNT with seed_cnt=0 on the next cycle.
- **clear_counters.** Clears err_count and bit_count. If it coincides with a counting strobe, the clear wins and both read 0 afterwards.
- **Reset mid-operation.** Reset is asynchronous and returns everything to reset values immediately.

## Timing
- `level` lags shaped_data by 1 cycle.
- The strobe samples `level` in the same cycle, so total latency from shaped_data to the bit decision is 1 cycle.
- rx_bit, rx_bit_valid, error_pulse, counter updates, state change, and lock are all registered 1 cycle after the strobe cycle.
- rise_time_meas and fall_time_meas update on the same edge as the `level` change.
- sample_strobe spacing must be at least 2 cycles.

## Test plan
- **Reset.** Assert reset mid-stream -> all outputs 0, state_dbg=0, within the same cycle (asynchronous).
- **Clean PRBS7 lock.** Clean PRBS7 from the shaper, edge time 4, strobe mid-symbol every 8 cycles -> lock rises one cycle after strobe #71 (7 seed + 64 match). After 1000 further strobes: bit_count=1000, err_count=0.
- **Single error and clear.** Flip one bit in LOCKED -> a single error_pulse and err_count=1, lock stays high. Then clear_counters coincident with a strobe -> err_count=0 and bit_count=0.
- **Edge measurement.** Linear 0->0x7FFF ramp lasting 8 cycles with default thresholds -> rise_time_meas equals the number of band samples (2). A 0-cycle step -> rise_time_meas=0.
- **All-zero input.** Constant 0x0000 input -> state never leaves HUNT, lock=0, bit_count=0.
- **Loss of lock.** 16 errors within one 128-bit window -> state_dbg returns to 0 on the 16th error and err_count=16 is retained. Changing prbs_sel while locked -> HUNT the next cycle.

Source files
------------

// File: rtl/prbs_rx_checker.sv
// Receive PRBS checker: hysteresis slicer, self-synchronising reference LFSR, BER counters, edge-time meter.
// Latency: slicer 1 cycle; rx_bit, error_pulse, counters and state registered 1 cycle after the strobe.
// No backpressure: one sample accepted every cycle; strobes must be at least 2 cycles apart.
module prbs_rx_checker #(
  parameter int LOCK_MATCHES = 64,
  parameter int LOL_WINDOW   = 128,
  parameter int LOL_ERRORS   = 16
) (
  input  logic        dac_clk,
  input  logic        reset,
  input  logic [15:0] shaped_data,
  input  logic        sample_strobe,
  input  logic [15:0] thr_hi,
  input  logic [15:0] thr_lo,
  input  logic [1:0]  prbs_sel,
  input  logic        clear_counters,
  output logic        rx_bit,
  output logic        rx_bit_valid,
  output logic        error_pulse,
  output logic        lock,
  output logic [1:0]  state_dbg,
  output logic [31:0] err_count,
  output logic [47:0] bit_count,
  output logic [7:0]  rise_time_meas,
  output logic [7:0]  fall_time_meas
);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [7:0]  LOCK_M  = 8'(LOCK_MATCHES);
  localparam logic [15:0] WIN_LEN = 16'(LOL_WINDOW);
  localparam logic [15:0] LOL_E   = 16'(LOL_ERRORS);

  logic        level;
  logic [7:0]  band_cnt;
  logic [1:0]  sel_q;
  logic        sel_change;
  state_t      state, state_nx;
  logic [30:0] lfsr, lfsr_nx, seeded, mask;
  logic [4:0]  seed_cnt, seed_nx, n_len, hi_idx, lo_idx;
  logic [7:0]  match_run, match_nx;
  logic [15:0] win_cnt, win_cnt_nx, win_err, win_err_nx;
  logic [31:0] err_nx;
  logic [47:0] bit_nx;
  logic        ep_nx, exp_bit;

  assign sel_change = (prbs_sel != sel_q);
  assign lock       = (state == LOCKED);
  assign state_dbg  = state;

  // Hysteresis slicer plus band-dwell timer; edge times latch on the level change itself.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      level          <= 1'b0;
      band_cnt       <= '0;
      rise_time_meas <= '0;
      fall_time_meas <= '0;
    end else begin
      if (shaped_data >= thr_hi) begin
        level <= 1'b1;
        if (!level) rise_time_meas <= band_cnt;
      end else if (shaped_data <= thr_lo) begin
        level <= 1'b0;
        if (level) fall_time_meas <= band_cnt;
      end
      if (shaped_data > thr_lo && shaped_data < thr_hi)
        band_cnt <= (band_cnt == 8'hFF) ? band_cnt : band_cnt + 8'd1;
      else
        band_cnt <= '0;
    end
  end

  // Polynomial decode: register width and the two Fibonacci tap positions.
  always_comb begin
    n_len  = 5'd7;
    hi_idx = 5'd6;
    lo_idx = 5'd5;
    mask   = 31'h7F;
    case (sel_q)
      2'd1: begin n_len = 5'd15; hi_idx = 5'd14; lo_idx = 5'd13; mask = 31'h7FFF;     end
      2'd2: begin n_len = 5'd23; hi_idx = 5'd22; lo_idx = 5'd17; mask = 31'h7F_FFFF;  end
      2'd3: begin n_len = 5'd31; hi_idx = 5'd30; lo_idx = 5'd27; mask = 31'h7FFF_FFFF; end
      default: ;
    endcase
  end

  // Sync FSM next state: seed from the line in HUNT, free-run the reference in CHECK/LOCKED.
  always_comb begin
    state_nx   = state;
    seed_nx    = seed_cnt;
    match_nx   = match_run;
    win_cnt_nx = win_cnt;
    win_err_nx = win_err;
    lfsr_nx    = lfsr;
    err_nx     = err_count;
    bit_nx     = bit_count;
    ep_nx      = 1'b0;
    exp_bit    = lfsr[hi_idx] ^ lfsr[lo_idx];
    seeded     = {lfsr[29:0], level};
    if (sel_change) begin
      state_nx = HUNT;
      seed_nx  = '0;
    end else if (sample_strobe) begin
      case (state)
        HUNT: begin
          lfsr_nx = seeded;
          if (seed_cnt + 5'd1 == n_len) begin
            seed_nx = '0;
            // An all-zero seed would lock the reference onto the zero sequence.
            if ((seeded & mask) != '0) begin
              state_nx = CHECK;
              match_nx = '0;
            end
          end else begin
            seed_nx = seed_cnt + 5'd1;
          end
        end
        CHECK: begin
          lfsr_nx = {lfsr[29:0], exp_bit};
          if (level != exp_bit) begin
            state_nx = HUNT;
            seed_nx  = '0;
          end else begin
            match_nx = match_run + 8'd1;
            if (match_nx == LOCK_M) begin
              state_nx   = LOCKED;
              win_cnt_nx = '0;
              win_err_nx = '0;
            end
          end
        end
        LOCKED: begin
          lfsr_nx    = {lfsr[29:0], exp_bit};
          win_cnt_nx = win_cnt + 16'd1;
          if (bit_count != '1) bit_nx = bit_count + 48'd1;
          if (level != exp_bit) begin
            if (err_count != '1) err_nx = err_count + 32'd1;
            ep_nx      = 1'b1;
            win_err_nx = win_err + 16'd1;
          end
          if (win_err_nx == LOL_E) begin
            state_nx = HUNT;
            seed_nx  = '0;
          end else if (win_cnt_nx == WIN_LEN) begin
            win_cnt_nx = '0;
            win_err_nx = '0;
          end
        end
        default: begin
          state_nx = HUNT;
          seed_nx  = '0;
        end
      endcase
    end
    // Clear has priority over a coincident counting strobe.
    if (clear_counters) begin
      err_nx = '0;
      bit_nx = '0;
    end
  end

  // State, reference and counter registers; bit outputs follow the strobe by one cycle.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      sel_q        <= '0;
      lfsr         <= '0;
      seed_cnt     <= '0;
      match_run    <= '0;
      win_cnt      <= '0;
      win_err      <= '0;
      err_count    <= '0;
      bit_count    <= '0;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      error_pulse  <= 1'b0;
    end else begin
      state        <= state_nx;
      sel_q        <= prbs_sel;
      lfsr         <= lfsr_nx;
      seed_cnt     <= seed_nx;
      match_run    <= match_nx;
      win_cnt      <= win_cnt_nx;
      win_err      <= win_err_nx;
      err_count    <= err_nx;
      bit_count    <= bit_nx;
      rx_bit_valid <= sample_strobe;
      error_pulse  <= ep_nx;
      if (sample_strobe) rx_bit <= level;
    end
  end

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Bench for prbs_rx_checker: randomized shaped PRBS stimulus against a behavioural reference.
// Outputs are compared on every falling edge; literal checks pin lock timing, counters and edge times.
// Inputs change 1 ns after the rising edge; reset is asserted asynchronously mid-stream.
module tb_prbs_rx_checker;
  localparam int LOCK_MATCHES = 64;
  localparam int LOL_WINDOW   = 128;
  localparam int LOL_ERRORS   = 16;

  logic        dac_clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] shaped_data = '0;
  logic        sample_strobe = 1'b0;
  logic [15:0] thr_hi = 16'h5000;
  logic [15:0] thr_lo = 16'h3000;
  logic [1:0]  prbs_sel = 2'd0;
  logic        clear_counters = 1'b0;
  logic        rx_bit, rx_bit_valid, error_pulse, lock;
  logic [1:0]  state_dbg;
  logic [31:0] err_count;
  logic [47:0] bit_count;
  logic [7:0]  rise_time_meas, fall_time_meas;

  always #5 dac_clk = ~dac_clk;

  prbs_rx_checker #(.LOCK_MATCHES(LOCK_MATCHES), .LOL_WINDOW(LOL_WINDOW), .LOL_ERRORS(LOL_ERRORS)) dut (
    .dac_clk(dac_clk), .reset(reset), .shaped_data(shaped_data), .sample_strobe(sample_strobe),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .prbs_sel(prbs_sel), .clear_counters(clear_counters),
    .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid), .error_pulse(error_pulse), .lock(lock),
    .state_dbg(state_dbg), .err_count(err_count), .bit_count(bit_count),
    .rise_time_meas(rise_time_meas), .fall_time_meas(fall_time_meas)
  );

  int n_checks = 0;
  int n_pass = 0;
  int ep_seen = 0;
  bit cmp_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  function automatic int poly_n(input logic [1:0] s);
    case (s)
      2'd0: return 7;
      2'd1: return 15;
      2'd2: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int poly_t(input logic [1:0] s);
    case (s)
      2'd0: return 6;
      2'd1: return 14;
      2'd2: return 18;
      default: return 28;
    endcase
  endfunction

  // ---------------- behavioural reference ----------------
  // Reference history is a queue of bits, newest at the back; expected bit for
  // x^N + x^T + 1 is the bit N places back XOR the bit T places back.
  bit          m_level;
  int          m_band, m_rise, m_fall;
  int          m_mode, m_seed, m_run, m_wpos, m_werr;
  bit          m_ref[$];
  longint      m_bits, m_errs;
  bit          m_rx, m_rxv, m_ep;
  logic [1:0]  m_sel_q;
  bit          lv_prev;
  bit          in_band;

  task automatic model_reset();
    m_level = 0; m_band = 0; m_rise = 0; m_fall = 0;
    m_mode = 0; m_seed = 0; m_run = 0; m_wpos = 0; m_werr = 0;
    m_ref.delete();
    for (int i = 0; i < 31; i++) m_ref.push_back(1'b0);
    m_bits = 0; m_errs = 0; m_rx = 0; m_rxv = 0; m_ep = 0; m_sel_q = 2'd0;
  endtask

  task automatic model_strobe(input bit rx);
    int n, t, sz;
    bit e, allz;
    n = poly_n(m_sel_q);
    t = poly_t(m_sel_q);
    sz = m_ref.size();
    e = m_ref[sz-n] ^ m_ref[sz-t];
    if (m_mode == 0) begin
      m_ref.push_back(rx);
      m_seed++;
      if (m_seed == n) begin
        m_seed = 0;
        allz = 1;
        for (int i = 1; i <= n; i++) if (m_ref[m_ref.size()-i]) allz = 0;
        if (!allz) begin m_mode = 1; m_run = 0; end
      end
    end else if (m_mode == 1) begin
      m_ref.push_back(e);
      if (rx != e) begin m_mode = 0; m_seed = 0; end
      else begin
        m_run++;
        if (m_run == LOCK_MATCHES) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
      end
    end else begin
      m_ref.push_back(e);
      if (m_bits < 64'hFFFF_FFFF_FFFF) m_bits++;
      if (rx != e) begin
        if (m_errs < 64'hFFFF_FFFF) m_errs++;
        m_ep = 1;
        m_werr++;
      end
      m_wpos++;
      if (m_werr == LOL_ERRORS) begin m_mode = 0; m_seed = 0; end
      else if (m_wpos == LOL_WINDOW) begin m_wpos = 0; m_werr = 0; end
    end
    while (m_ref.size() > 64) m_ref.delete(0);
  endtask

  always @(posedge dac_clk or posedge reset) begin
    if (reset) model_reset();
    else begin
      lv_prev = m_level;
      m_rxv = sample_strobe;
      m_ep = 0;
      if (sample_strobe) m_rx = lv_prev;
      if (prbs_sel != m_sel_q) begin m_sel_q = prbs_sel; m_mode = 0; m_seed = 0; end
      else if (sample_strobe) model_strobe(lv_prev);
      if (clear_counters) begin m_bits = 0; m_errs = 0; end
      in_band = (shaped_data > thr_lo) && (shaped_data < thr_hi);
      if (shaped_data >= thr_hi) begin if (!m_level) m_rise = m_band; m_level = 1; end
      else if (shaped_data <= thr_lo) begin if (m_level) m_fall = m_band; m_level = 0; end
      if (in_band) m_band = (m_band < 255) ? m_band + 1 : 255;
      else m_band = 0;
    end
  end

  always @(negedge dac_clk) begin
    if (cmp_en) begin
      check("state_dbg", 64'(state_dbg), 64'(m_mode));
      check("lock", 64'(lock), 64'(m_mode == 2));
      check("err_count", 64'(err_count), 64'(m_errs));
      check("bit_count", 64'(bit_count), 64'(m_bits));
      check("error_pulse", 64'(error_pulse), 64'(m_ep));
      check("rx_bit_valid", 64'(rx_bit_valid), 64'(m_rxv));
      check("rx_bit", 64'(rx_bit), 64'(m_rx));
      check("rise_time_meas", 64'(rise_time_meas), 64'(m_rise));
      check("fall_time_meas", 64'(fall_time_meas), 64'(m_fall));
      if (error_pulse) ep_seen++;
    end
  end

  // ---------------- stimulus ----------------
  bit tx_hist[$];
  int tx_pos, tx_n, tx_t;
  bit last_drv = 1'b0;

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic tx_restart(input logic [1:0] s);
    tx_hist.delete();
    tx_pos = 0;
    tx_n = poly_n(s);
    tx_t = poly_t(s);
    for (int i = 0; i < tx_n; i++) tx_hist.push_back(1'($urandom_range(0, 1)));
    tx_hist[0] = 1'b1;
  endtask

  task automatic tx_next(output bit b);
    int sz;
    if (tx_pos >= tx_hist.size()) begin
      sz = tx_hist.size();
      tx_hist.push_back(tx_hist[sz-tx_n] ^ tx_hist[sz-tx_t]);
    end
    b = tx_hist[tx_pos];
    tx_pos++;
  endtask

  function automatic logic [15:0] band_val();
    return 16'($urandom_range(16'h3001, 16'h4FFF));
  endfunction

  // One 8-cycle symbol; transitions dwell 0..3 cycles in the band, strobe at cycle 4.
  task automatic send_sym(input bit b, input bit flip, input bit clr, output bit lk);
    bit d;
    int r;
    d = b ^ flip;
    r = (d != last_drv) ? int'($urandom_range(0, 3)) : 0;
    lk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < r) shaped_data = band_val();
      else if (i >= 5 && $urandom_range(0, 3) == 0) shaped_data = band_val();
      else shaped_data = d ? 16'($urandom_range(16'h5000, 16'hFFFF)) : 16'($urandom_range(0, 16'h3000));
      sample_strobe = (i == 4);
      clear_counters = (i == 4) && clr;
      tick();
      if (i == 4) lk = lock;
    end
    last_drv = d;
    sample_strobe = 1'b0;
    clear_counters = 1'b0;
  endtask

  task automatic send_run(input int n, input int flip_pct, input int clr_pct);
    bit b, lk, fl, cl;
    for (int k = 0; k < n; k++) begin
      tx_next(b);
      fl = (int'($urandom_range(0, 99)) < flip_pct);
      cl = (int'($urandom_range(0, 99)) < clr_pct);
      send_sym(b, fl, cl, lk);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 64'(state_dbg), 64'd0);
    check({tag, "_lock"}, 64'(lock), 64'd0);
    check({tag, "_err"}, 64'(err_count), 64'd0);
    check({tag, "_bits"}, 64'(bit_count), 64'd0);
    check({tag, "_rxv"}, 64'(rx_bit_valid), 64'd0);
    check({tag, "_rx"}, 64'(rx_bit), 64'd0);
    check({tag, "_ep"}, 64'(error_pulse), 64'd0);
    check({tag, "_rise"}, 64'(rise_time_meas), 64'd0);
    check({tag, "_fall"}, 64'(fall_time_meas), 64'd0);
  endtask

  initial begin
    bit b, lk;
    int ep0;
    model_reset();
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;

    // Edge measurement: 8-cycle linear ramp to 0x7FFF has 2 band samples.
    tick(); tick();
    for (int k = 0; k < 8; k++) begin shaped_data = 16'(k * 32767 / 7); tick(); end
    check("ramp_rise", 64'(rise_time_meas), 64'd2);
    shaped_data = 16'h7FFF; tick(); tick();
    for (int k = 0; k < 5; k++) begin shaped_data = 16'h4000; tick(); end
    shaped_data = 16'h0000; tick();
    check("fall_5", 64'(fall_time_meas), 64'd5);
    shaped_data = 16'hFFFF; tick();
    check("step_rise", 64'(rise_time_meas), 64'd0);
    for (int k = 0; k < 300; k++) begin shaped_data = 16'h4000; tick(); end
    shaped_data = 16'h0000; tick();
    check("fall_sat", 64'(fall_time_meas), 64'd255);
    for (int k = 0; k < 3; k++) begin shaped_data = 16'h4000; tick(); end
    shaped_data = 16'h5000; tick();
    check("rise_hyst", 64'(rise_time_meas), 64'd3);
    shaped_data = 16'h3000; tick();
    last_drv = 1'b0;

    // Clean PRBS7: lock one cycle after strobe 71.
    tx_restart(2'd0);
    for (int k = 1; k <= 71; k++) begin
      tx_next(b);
      send_sym(b, 1'b0, 1'b0, lk);
      if (k == 70) check("lock_after_70", 64'(lk), 64'd0);
    end
    check("lock_after_71", 64'(lk), 64'd1);
    send_run(1000, 0, 0);
    check("bits_1000", 64'(bit_count), 64'd1000);
    check("errs_0", 64'(err_count), 64'd0);

    // Single error, then clear coincident with a strobe.
    ep0 = ep_seen;
    tx_next(b);
    send_sym(b, 1'b1, 1'b0, lk);
    send_run(10, 0, 0);
    check("single_err", 64'(err_count), 64'd1);
    check("single_pulses", 64'(ep_seen - ep0), 64'd1);
    check("single_lock", 64'(lock), 64'd1);
    tx_next(b);
    send_sym(b, 1'b0, 1'b1, lk);
    check("clear_err", 64'(err_count), 64'd0);
    check("clear_bits", 64'(bit_count), 64'd0);
    send_run(5, 0, 0);

    // Asynchronous reset mid-stream.
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    tick(); tick();
    reset = 1'b0;

    // Loss of lock: 16 errors inside the first window.
    tx_restart(2'd0);
    send_run(71, 0, 0);
    send_run(10, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      tx_next(b);
      send_sym(b, 1'b1, 1'b0, lk);
      if (k == 15) check("lol_state_15", 64'(state_dbg), 64'd2);
    end
    check("lol_state_16", 64'(state_dbg), 64'd0);
    check("lol_errs", 64'(err_count), 64'd16);
    send_run(20, 0, 0);
    check("lol_errs_kept", 64'(err_count), 64'd16);
    send_run(100, 0, 0);
    check("relock", 64'(lock), 64'd1);

    // prbs_sel change forces HUNT next cycle, then PRBS15 locks after 15 + 64 strobes.
    prbs_sel = 2'd1;
    tick();
    check("sel_hunt", 64'(state_dbg), 64'd0);
    tx_restart(2'd1);
    for (int k = 1; k <= 79; k++) begin
      tx_next(b);
      send_sym(b, 1'b0, 1'b0, lk);
      if (k == 78) check("p15_lock_78", 64'(lk), 64'd0);
    end
    check("p15_lock_79", 64'(lk), 64'd1);

    // Randomized phases: polynomial, error rate and clears.
    for (int ph = 0; ph < 6; ph++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      if (s != prbs_sel) begin prbs_sel = s; tick(); end
      tx_restart(s);
      send_run(110, 0, 1);
      send_run(60, (ph % 3 == 0) ? 1 : ((ph % 3 == 1) ? 5 : 25), 1);
      send_run(20, 0, 0);
    end

    // All-zero input never leaves HUNT.
    reset = 1'b1;
    prbs_sel = 2'd0;
    shaped_data = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < 8; i++) begin
        sample_strobe = (i == 4);
        tick();
      end
      check("zero_state", 64'(state_dbg), 64'd0);
    end
    sample_strobe = 1'b0;
    check("zero_lock", 64'(lock), 64'd0);
    check("zero_bits", 64'(bit_count), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
